// File: rtl/alu_pipe.sv
// alu_pipe: DEPTH-entry issue FIFO feeding a single-cycle integer ALU whose result slot waits for a CDB grant
module alu_pipe #(
  parameter int XLEN    = 32,
  parameter int ROB_BIT = 4,
  parameter int IMM_W   = 12,
  parameter int DEPTH   = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_vj,
  input  logic [XLEN-1:0]          in_vk,
  input  logic [IMM_W-1:0]         in_imm,
  input  logic [2:0]               in_op,
  input  logic                     in_has_imm,
  input  logic                     in_op_alt,
  input  logic [ROB_BIT-1:0]       in_rob_entry,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_res,
  output logic [ROB_BIT-1:0]       out_rob_entry,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(XLEN);
  typedef struct packed {
    logic [XLEN-1:0]    a;
    logic [XLEN-1:0]    b;
    logic [2:0]         op;
    logic               sub;
    logic               alt;
    logic [ROB_BIT-1:0] rob;
  } entry_t;
  entry_t mem_q [DEPTH];
  entry_t mem_d [DEPTH];
  entry_t in_e, head;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0] count_q, count_d;
  logic out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_res_q, out_res_d, res, sra_r;
  logic [ROB_BIT-1:0] out_rob_q, out_rob_d;
  logic [SW-1:0] sh;
  logic push, pop, drain;
  assign in_e = '{a: in_vj,
                  b: in_has_imm ? XLEN'($signed(in_imm)) : in_vk,
                  op: in_op,
                  sub: ~in_has_imm & in_op_alt,
                  alt: in_op_alt,
                  rob: in_rob_entry};
  assign head  = mem_q[rd_ptr_q];
  assign sh    = head.b[SW-1:0];
  assign sra_r = $signed(head.a) >>> sh;
  assign res = head.op == 3'd0 ? (head.sub ? head.a - head.b : head.a + head.b) :
               head.op == 3'd1 ? head.a << sh :
               head.op == 3'd2 ? XLEN'($signed(head.a) < $signed(head.b)) :
               head.op == 3'd3 ? XLEN'(head.a < head.b) :
               head.op == 3'd4 ? head.a ^ head.b :
               head.op == 3'd5 ? (head.alt ? sra_r : head.a >> sh) :
               head.op == 3'd6 ? head.a | head.b :
                                 head.a & head.b;
  assign in_ready = rdy_in & ~clear_in & ~count_q[PW];
  assign push     = in_valid & in_ready;
  assign pop      = rdy_in & ~clear_in & (count_q != '0) & (~out_valid_q | out_ready);
  assign drain    = rdy_in & out_valid_q & out_ready;
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_res_d   = out_res_q;
    out_rob_d   = out_rob_q;
    if (clear_in) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_e;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d    = rd_ptr_q + PW'(1);
        out_valid_d = 1'b1;
        out_res_d   = res;
        out_rob_d   = head.rob;
      end else if (drain) begin
        out_valid_d = 1'b0;
      end
      count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_rob_q   <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      out_rob_q   <= out_rob_d;
    end
  end
  assign out_valid     = out_valid_q;
  assign out_res       = out_res_q;
  assign out_rob_entry = out_rob_q;
  assign count         = count_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed table-driven checks of alu_pipe arithmetic, latency, backpressure, wrap, flush and freeze
module tb_alu_pipe;
  logic clk_in = 1'b0, rst_in, rdy_in, clear_in, in_valid, in_ready;
  logic [31:0] in_vj, in_vk, out_res;
  logic [11:0] in_imm;
  logic [2:0] in_op;
  logic in_has_imm, in_op_alt, out_valid, out_ready;
  logic [3:0] in_rob_entry, out_rob_entry;
  logic [2:0] count;
  int checks = 0, failures = 0;
  alu_pipe dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_vj(in_vj), .in_vk(in_vk),
    .in_imm(in_imm), .in_op(in_op), .in_has_imm(in_has_imm), .in_op_alt(in_op_alt),
    .in_rob_entry(in_rob_entry), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_rob_entry(out_rob_entry), .count(count)
  );
  always #5 clk_in = ~clk_in;
  typedef struct {
    logic [31:0] vj, vk;
    logic [11:0] imm;
    logic [2:0]  op;
    logic        has_imm, alt;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [16];
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic issue(input logic [31:0] vj, input logic [31:0] vk, input logic [11:0] imm,
                       input logic [2:0] op, input logic has_imm, input logic alt, input logic [3:0] tag);
    in_valid = 1'b1;
    in_vj = vj;
    in_vk = vk;
    in_imm = imm;
    in_op = op;
    in_has_imm = has_imm;
    in_op_alt = alt;
    in_rob_entry = tag;
  endtask
  initial begin
    vecs[0]  = '{32'd5, 32'd7, 12'h0, 3'd0, 1'b0, 1'b0, 32'h0000000C};
    vecs[1]  = '{32'd5, 32'd7, 12'h0, 3'd0, 1'b0, 1'b1, 32'hFFFFFFFE};
    vecs[2]  = '{32'h10, 32'h0, 12'hFFF, 3'd0, 1'b1, 1'b0, 32'h0000000F};
    vecs[3]  = '{32'h80000000, 32'h0, 12'h004, 3'd5, 1'b1, 1'b1, 32'hF8000000};
    vecs[4]  = '{32'hFFFFFFFF, 32'h0, 12'h000, 3'd2, 1'b1, 1'b0, 32'h00000001};
    vecs[5]  = '{32'h1, 32'd33, 12'h0, 3'd1, 1'b0, 1'b0, 32'h00000002};
    vecs[6]  = '{32'h1, 32'hFFFFFFFF, 12'h0, 3'd3, 1'b0, 1'b0, 32'h00000001};
    vecs[7]  = '{32'h1, 32'hFFFFFFFF, 12'h0, 3'd2, 1'b0, 1'b0, 32'h00000000};
    vecs[8]  = '{32'hF0F0, 32'hFF00, 12'h0, 3'd4, 1'b0, 1'b0, 32'h00000FF0};
    vecs[9]  = '{32'h80000000, 32'd4, 12'h0, 3'd5, 1'b0, 1'b0, 32'h08000000};
    vecs[10] = '{32'hA0, 32'h05, 12'h0, 3'd6, 1'b0, 1'b0, 32'h000000A5};
    vecs[11] = '{32'hFF, 32'h0F, 12'h0, 3'd7, 1'b0, 1'b0, 32'h0000000F};
    vecs[12] = '{32'd5, 32'h0, 12'h001, 3'd0, 1'b1, 1'b1, 32'h00000006};
    vecs[13] = '{32'hF0000000, 32'h0, 12'h004, 3'd5, 1'b1, 1'b0, 32'h0F000000};
    vecs[14] = '{32'hFFFFFFFF, 32'd2, 12'h0, 3'd0, 1'b0, 1'b0, 32'h00000001};
    vecs[15] = '{32'h1, 32'd31, 12'h0, 3'd1, 1'b0, 1'b0, 32'h80000000};
    rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_vj = '0; in_vk = '0; in_imm = '0; in_op = '0;
    in_has_imm = 1'b0; in_op_alt = 1'b0; in_rob_entry = '0;
    repeat (2) step();
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_res", out_res, 0);
    chk("rst_rob", out_rob_entry, 0);
    rst_in = 1'b1;
    step();
    chk("rst_in_ready", in_ready, 1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(i, 0, 0, 3'd0, 1'b0, 1'b0, 4'(i));
      step();
    end
    in_valid = 1'b0;
    chk("mid_pre_count", count, 2);
    #2 rst_in = 1'b0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", out_valid, 0);
    step();
    rst_in = 1'b1;
    step();
    chk("mid_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    issue(5, 7, 0, 3'd0, 1'b0, 1'b0, 4'd1);
    step();
    issue(5, 7, 0, 3'd0, 1'b0, 1'b1, 4'd2);
    step();
    chk("b2b_res1", {out_valid, out_rob_entry, out_res}, {1'b1, 4'd1, 32'h0000000C});
    in_valid = 1'b0;
    step();
    chk("b2b_res2", {out_valid, out_rob_entry, out_res}, {1'b1, 4'd2, 32'hFFFFFFFE});
    step();
    chk("b2b_drained", out_valid, 0);
    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].vj, vecs[i].vk, vecs[i].imm, vecs[i].op, vecs[i].has_imm, vecs[i].alt, 4'(i));
      step();
      in_valid = 1'b0;
      step();
      chk($sformatf("vec%0d", i), {out_valid, out_rob_entry, out_res}, {1'b1, 4'(i), vecs[i].exp});
    end
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      issue(i, 0, 0, 3'd0, 1'b0, 1'b0, 4'(10 + i));
      step();
    end
    chk("bp_count", count, 4);
    chk("bp_in_ready", in_ready, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("bp_drain%0d", j), {out_valid, out_rob_entry, out_res}, {1'b1, 4'(10 + j), 32'(j)});
      step();
    end
    chk("bp_empty", {out_valid, count}, {1'b0, 3'd0});
    out_ready = 1'b0;
    for (int n = 0; n < 4; n++) begin
      issue(n, 100, 0, 3'd0, 1'b0, 1'b0, 4'(n));
      step();
    end
    chk("wrap_fill", count, 3);
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      issue(4 + i, 100, 0, 3'd0, 1'b0, 1'b0, 4'(4 + i));
      step();
      chk($sformatf("wrap_cnt%0d", i), count, 3);
      chk($sformatf("wrap_res%0d", i), {out_valid, out_rob_entry, out_res}, {1'b1, 4'(i + 1), 32'(i + 101)});
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("wrap_tail%0d", i), {out_valid, out_rob_entry, out_res, count}, {1'b1, 4'(13 + i), 32'(113 + i), 3'(2 - i)});
    end
    step();
    chk("wrap_empty", out_valid, 0);
    out_ready = 1'b0;
    issue(1, 0, 0, 3'd0, 1'b0, 1'b0, 4'd5);
    step();
    issue(2, 0, 0, 3'd0, 1'b0, 1'b0, 4'd6);
    step();
    issue(3, 0, 0, 3'd0, 1'b0, 1'b0, 4'd7);
    clear_in = 1'b1;
    #1;
    chk("clr_pre_valid", out_valid, 1);
    chk("clr_in_ready", in_ready, 0);
    step();
    chk("clr_state", {out_valid, count}, {1'b0, 3'd0});
    clear_in = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("clr_dropped%0d", i), out_valid, 0);
    end
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      issue(i, 0, 0, 3'd0, 1'b0, 1'b0, 4'(i));
      step();
    end
    rdy_in = 1'b0;
    out_ready = 1'b1;
    issue(9, 0, 0, 3'd0, 1'b0, 1'b0, 4'd9);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("frz%0d", i), {out_valid, out_rob_entry, out_res, count, in_ready}, {1'b1, 4'd1, 32'd1, 3'd2, 1'b0});
    end
    rdy_in = 1'b1;
    in_valid = 1'b0;
    step();
    chk("frz_after1", {out_valid, out_rob_entry, out_res}, {1'b1, 4'd2, 32'd2});
    step();
    chk("frz_after2", {out_valid, out_rob_entry, out_res}, {1'b1, 4'd3, 32'd3});
    step();
    chk("frz_final", {out_valid, count}, {1'b0, 3'd0});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
